// File: rtl/img_conv_pkg.sv
// Shared opcode encoding for the image-convolution SoC command port.
package img_conv_pkg;

  // 4-bit field leaves room for opcodes this block does not know about.
  typedef enum logic [3:0] {
    OP_NOP       = 4'h0,
    OP_SET_NROWS = 4'h1,
    OP_SET_NCOLS = 4'h2,
    OP_GET_NROWS = 4'h3,
    OP_GET_NCOLS = 4'h4,
    OP_IMG_RX    = 4'h5,
    OP_IMG_TX    = 4'h6,
    OP_CONV      = 4'h7
  } opcode_t;

endpackage

// File: rtl/img_conv_host_ctrl_if.sv
// Bundle of host command, pixel stream and SoC-side signals for img_conv_host_ctrl.
// master: the controller's view; slave: the surrounding bridge/SoC view.
interface img_conv_host_ctrl_if ();
  import img_conv_pkg::*;

  // Host command / response
  logic       cmd_valid;
  logic       cmd_ready;
  opcode_t    cmd_op;
  logic [7:0] cmd_arg;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       err;

  // Upload (into SoC) and download (out of SoC) pixel streams
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;

  // SoC command port
  opcode_t    soc_op;
  logic       soc_en;
  logic [7:0] soc_din;
  logic [7:0] soc_dout;
  logic       soc_busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_arg, s_data, s_valid, soc_dout, soc_busy,
    output cmd_ready, rsp_valid, rsp_data, err, s_ready, m_data, m_valid,
           soc_op, soc_en, soc_din
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_arg, s_data, s_valid, soc_dout, soc_busy,
    input  cmd_ready, rsp_valid, rsp_data, err, s_ready, m_data, m_valid,
           soc_op, soc_en, soc_din
  );

endinterface

// File: rtl/img_conv_host_ctrl.sv
// Host-side initiator for the image-convolution SoC: issues one en pulse per command,
// streams pixels in/out around SoC busy, and returns GET results. All outputs registered.
module img_conv_host_ctrl
  import img_conv_pkg::*;
#(
  parameter int unsigned CONV_WAIT    = 4096,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input logic                  clk,
  input logic                  rst,
  img_conv_host_ctrl_if.master bus
);

  localparam logic [15:0] ConvLast = 16'(CONV_WAIT - 1);
  localparam logic [15:0] BusyLast = 16'(BUSY_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StIssue,
    StGetWait,
    StRxWait,
    StTxWait,
    StRxStream,
    StTxStream,
    StRxDrain,
    StTxDrain,
    StConvWait,
    StDone
  } state_t;

  state_t      state_q, state_d;
  opcode_t     op_q, op_d;
  logic [7:0]  arg_q, arg_d;
  logic [7:0]  nrows_q, nrows_d;
  logic [7:0]  ncols_q, ncols_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        err_q, err_d;
  logic        s_ready_q, s_ready_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  opcode_t     soc_op_q, soc_op_d;
  logic        soc_en_q, soc_en_d;
  logic [7:0]  soc_din_q, soc_din_d;

  logic [7:0]  rows_eff, cols_eff;
  logic [15:0] npix;

  // Pixel count with zero dimensions treated as one.
  always_comb begin
    rows_eff = (nrows_q == 8'd0) ? 8'd1 : nrows_q;
    cols_eff = (ncols_q == 8'd0) ? 8'd1 : ncols_q;
    npix     = {8'd0, rows_eff} * {8'd0, cols_eff};
  end

  // Next state plus registered-output values; outputs keyed to the state being entered.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    arg_d       = arg_q;
    nrows_d     = nrows_q;
    ncols_d     = ncols_q;
    pix_cnt_d   = pix_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    soc_din_d   = 8'd0;
    m_data_d    = 8'd0;
    m_valid_d   = 1'b0;

    case (state_q)
      StIdle: begin
        // cmd_ready_q is low for the one cycle after reset, so nothing is taken then.
        if (cmd_ready_q && bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          arg_d   = bus.cmd_arg;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wait_cnt_d = 16'd0;
        case (op_q)
          OP_GET_NROWS, OP_GET_NCOLS: state_d = StGetWait;
          OP_SET_NROWS: begin
            nrows_d = arg_q;
            state_d = StDone;
          end
          OP_SET_NCOLS: begin
            ncols_d = arg_q;
            state_d = StDone;
          end
          OP_IMG_RX: state_d = StRxWait;
          OP_IMG_TX: state_d = StTxWait;
          OP_CONV:   state_d = StConvWait;
          default:   state_d = StDone;
        endcase
      end
      StGetWait: begin
        // SoC registered dout on the issue edge.
        rsp_data_d = bus.soc_dout;
        state_d    = StDone;
      end
      StRxWait, StTxWait: begin
        if (bus.soc_busy) begin
          pix_cnt_d = npix;
          state_d   = (state_q == StRxWait) ? StRxStream : StTxStream;
        end else if (wait_cnt_q == BusyLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StRxStream: begin
        // The SoC cannot stall: a missing byte is sent as zero and flagged.
        soc_din_d = bus.s_valid ? bus.s_data : 8'd0;
        if (!bus.s_valid) begin
          err_d = 1'b1;
        end
        pix_cnt_d = pix_cnt_q - 16'd1;
        if (pix_cnt_q == 16'd1) begin
          state_d = StRxDrain;
        end
      end
      StTxStream: begin
        m_valid_d = 1'b1;
        m_data_d  = bus.soc_dout;
        pix_cnt_d = pix_cnt_q - 16'd1;
        if (pix_cnt_q == 16'd1) begin
          state_d = StTxDrain;
        end
      end
      StRxDrain, StTxDrain: begin
        if (!bus.soc_busy) begin
          state_d = StDone;
        end
      end
      StConvWait: begin
        // SoC gives no busy during convolution; hold off for a fixed time.
        if (wait_cnt_q == ConvLast) begin
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    cmd_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StDone);
    s_ready_d   = (state_d == StRxStream);
    soc_en_d    = (state_d == StIssue);
    soc_op_d    = soc_en_d ? op_d : OP_NOP;
    if (soc_en_d) begin
      soc_din_d = arg_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OP_NOP;
      arg_q       <= 8'd0;
      nrows_q     <= 8'd8;
      ncols_q     <= 8'd8;
      pix_cnt_q   <= 16'd0;
      wait_cnt_q  <= 16'd0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      err_q       <= 1'b0;
      s_ready_q   <= 1'b0;
      m_data_q    <= 8'd0;
      m_valid_q   <= 1'b0;
      soc_op_q    <= OP_NOP;
      soc_en_q    <= 1'b0;
      soc_din_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      arg_q       <= arg_d;
      nrows_q     <= nrows_d;
      ncols_q     <= ncols_d;
      pix_cnt_q   <= pix_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      s_ready_q   <= s_ready_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      soc_op_q    <= soc_op_d;
      soc_en_q    <= soc_en_d;
      soc_din_q   <= soc_din_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.err       = err_q;
  assign bus.s_ready   = s_ready_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.soc_op    = soc_op_q;
  assign bus.soc_en    = soc_en_q;
  assign bus.soc_din   = soc_din_q;

endmodule
